// File: rtl/booth_mult_if.sv
// Start/busy coprocessor bundle for booth_mult; the done pulse exists only when MULT_DONE_EN is defined.
// master drives operands and start, slave returns the registered product and status.
interface booth_mult_if #(
  parameter int MBITS = 12,
  parameter int NBITS = 8
);
  logic                   start;
  logic [MBITS-1:0]       mpd;
  logic [NBITS-1:0]       mpr;
  logic [MBITS+NBITS-1:0] prod;
  logic                   busy;
`ifdef MULT_DONE_EN
  logic                   done;

  modport master (output start, mpd, mpr, input prod, busy, done);
  modport slave  (input start, mpd, mpr, output prod, busy, done);
`else
  modport master (output start, mpd, mpr, input prod, busy);
  modport slave  (input start, mpd, mpr, output prod, busy);
`endif
endinterface

// File: rtl/booth_mult.sv
// Sequential radix-2 Booth signed multiplier, one step per clock; MULT_DONE_EN adds a one-cycle done pulse.
// Latency NBITS cycles from the start edge; start is ignored while busy, no queueing of requests.
module booth_mult #(
  parameter int MBITS = 12,
  parameter int NBITS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  booth_mult_if.slave  bus
);
  localparam int CW = $clog2(NBITS + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state_q;
  logic [MBITS-1:0]       m_q;
  logic [MBITS:0]         a_q;
  logic [NBITS-1:0]       q_q;
  logic                   q1_q;
  logic [CW-1:0]          cnt_q;
  logic [MBITS+NBITS-1:0] prod_q;
  logic                   busy_q;
`ifdef MULT_DONE_EN
  logic                   done_q;
`endif

  logic [MBITS:0]         m_ext;
  logic [MBITS:0]         a_sum;
  logic [MBITS:0]         a_d;
  logic [NBITS-1:0]       q_d;
  logic                   q1_d;
  logic                   last_step;

  // Extra accumulator bit keeps A - (-2^(MBITS-1)) from wrapping.
  always_comb begin
    m_ext = {m_q[MBITS-1], m_q};
    case ({q_q[0], q1_q})
      2'b01:   a_sum = a_q + m_ext;
      2'b10:   a_sum = a_q - m_ext;
      default: a_sum = a_q;
    endcase
  end

  assign a_d       = {a_sum[MBITS], a_sum[MBITS:1]};
  assign q_d       = {a_sum[0], q_q[NBITS-1:1]};
  assign q1_d      = q_q[0];
  assign last_step = (cnt_q == CW'(NBITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
`ifdef MULT_DONE_EN
      done_q  <= 1'b0;
`endif
    end else begin
`ifdef MULT_DONE_EN
      done_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            m_q     <= bus.mpd;
            a_q     <= '0;
            q_q     <= bus.mpr;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_d;
          q_q   <= q_d;
          q1_q  <= q1_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_step) begin
            prod_q  <= {a_d[MBITS-1:0], q_d};
            busy_q  <= 1'b0;
            state_q <= IDLE;
`ifdef MULT_DONE_EN
            done_q  <= 1'b1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.prod = prod_q;
  assign bus.busy = busy_q;
`ifdef MULT_DONE_EN
  assign bus.done = done_q;
`endif

endmodule

// File: tb/tb_booth_mult.sv
// Directed-vector bench for booth_mult: products, latency, start handling, async reset abort.
module tb_booth_mult;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  booth_mult_if #(.MBITS(12), .NBITS(8)) bus ();

  booth_mult #(.MBITS(12), .NBITS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation from a negedge and wait (bounded) for busy to fall.
  task automatic launch(input logic [11:0] a, input logic [7:0] b,
                        output int cyc, output int dn, output bit stable);
    logic [19:0] p0;
    p0 = bus.prod;
    bus.mpd = a;
    bus.mpr = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    dn = 0;
    stable = 1'b1;
    while (bus.busy === 1'b1 && cyc < 50) begin
      cyc++;
      if (bus.prod !== p0) stable = 1'b0;
`ifdef MULT_DONE_EN
      if (bus.done === 1'b1) dn++;
`endif
      @(negedge clk);
    end
`ifdef MULT_DONE_EN
    if (bus.done === 1'b1) dn++;
`endif
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++;
    if (bus.prod !== 20'h0) begin n_bad++; $display("FAIL reset_prod: got %h want 00000", bus.prod); end
`ifdef MULT_DONE_EN
    n_cmp++;
    if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pos_pos;
    int cyc, dn;
    bit st;
    launch(12'h100, 8'h40, cyc, dn, st);
    n_cmp++;
    if (cyc !== 8) begin n_bad++; $display("FAIL pos_pos_latency: got %0d want 8", cyc); end
    n_cmp++;
    if (bus.prod !== 20'h04000) begin n_bad++; $display("FAIL pos_pos_prod: got %h want 04000", bus.prod); end
  endtask

  task automatic test_neg_pos;
    int cyc, dn;
    bit st;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.prod !== 20'h04000) begin n_bad++; $display("FAIL neg_pos_prior: got %h want 04000", bus.prod); end
    launch(12'hB00, 8'h40, cyc, dn, st);
    n_cmp++;
    if (st !== 1'b1) begin n_bad++; $display("FAIL neg_pos_held: got %b want 1", st); end
    n_cmp++;
    if (cyc !== 8) begin n_bad++; $display("FAIL neg_pos_latency: got %0d want 8", cyc); end
    n_cmp++;
    if (bus.prod !== 20'hEC000) begin n_bad++; $display("FAIL neg_pos_prod: got %h want EC000", bus.prod); end
  endtask

  task automatic test_extremes;
    int cyc, dn;
    bit st;
    launch(12'h800, 8'h80, cyc, dn, st);
    n_cmp++;
    if (bus.prod !== 20'h40000) begin n_bad++; $display("FAIL ext_minmin: got %h want 40000", bus.prod); end
    launch(12'h7FF, 8'h80, cyc, dn, st);
    n_cmp++;
    if (bus.prod !== 20'hC0080) begin n_bad++; $display("FAIL ext_maxmin: got %h want C0080", bus.prod); end
    launch(12'h7FF, 8'h7F, cyc, dn, st);
    n_cmp++;
    if (bus.prod !== 20'h3F781) begin n_bad++; $display("FAIL ext_maxmax: got %h want 3F781", bus.prod); end
  endtask

  task automatic test_zero_alt;
    int cyc, dn;
    bit st;
    launch(12'h123, 8'h00, cyc, dn, st);
    n_cmp++;
    if (bus.prod !== 20'h00000) begin n_bad++; $display("FAIL zero_mpr: got %h want 00000", bus.prod); end
    launch(12'hFFF, 8'h55, cyc, dn, st);
    n_cmp++;
    if (bus.prod !== 20'hFFFAB) begin n_bad++; $display("FAIL alt_bits: got %h want FFFAB", bus.prod); end
  endtask

  task automatic test_start_held;
    int cyc;
    bus.mpd = 12'h005;
    bus.mpr = 8'hFD;
    bus.start = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 50) begin
      cyc++;
      case (cyc)
        1: begin bus.mpd = 12'h7FF; bus.mpr = 8'h11; end
        3: bus.start = 1'b0;
        5: bus.start = 1'b1;
        6: bus.start = 1'b0;
        default: ;
      endcase
      @(negedge clk);
    end
    n_cmp++;
    if (cyc !== 8) begin n_bad++; $display("FAIL held_latency: got %0d want 8", cyc); end
    n_cmp++;
    if (bus.prod !== 20'hFFFF1) begin n_bad++; $display("FAIL held_prod: got %h want FFFF1", bus.prod); end
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL held_no_requeue: got %b want 0", bus.busy); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    bus.mpd = 12'h003;
    bus.mpr = 8'h07;
    bus.start = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 50) begin cyc++; @(negedge clk); end
    n_cmp++;
    if (cyc !== 8) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want 8", cyc); end
    n_cmp++;
    if (bus.prod !== 20'h00015) begin n_bad++; $display("FAIL b2b_first_prod: got %h want 00015", bus.prod); end
    bus.mpd = 12'hFFE;
    bus.mpr = 8'h03;
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_restart: got %b want 1", bus.busy); end
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 50) begin cyc++; @(negedge clk); end
    n_cmp++;
    if (cyc !== 8) begin n_bad++; $display("FAIL b2b_second_latency: got %0d want 8", cyc); end
    n_cmp++;
    if (bus.prod !== 20'hFFFFA) begin n_bad++; $display("FAIL b2b_second_prod: got %h want FFFFA", bus.prod); end
  endtask

  task automatic test_reset_mid;
    int cyc, dn;
    bit st;
    dn = 0;
    bus.mpd = 12'h100;
    bus.mpr = 8'h40;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef MULT_DONE_EN
      if (bus.done === 1'b1) dn++;
`endif
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    n_cmp++;
    if (bus.prod !== 20'h0) begin n_bad++; $display("FAIL abort_prod: got %h want 00000", bus.prod); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
`ifdef MULT_DONE_EN
      if (bus.done === 1'b1) dn++;
`endif
      @(negedge clk);
    end
`ifdef MULT_DONE_EN
    n_cmp++;
    if (dn !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", dn); end
`endif
    launch(12'hB00, 8'h40, cyc, dn, st);
    n_cmp++;
    if (cyc !== 8) begin n_bad++; $display("FAIL post_abort_latency: got %0d want 8", cyc); end
    n_cmp++;
    if (bus.prod !== 20'hEC000) begin n_bad++; $display("FAIL post_abort_prod: got %h want EC000", bus.prod); end
`ifdef MULT_DONE_EN
    n_cmp++;
    if (dn !== 1) begin n_bad++; $display("FAIL post_abort_done: got %0d pulses want 1", dn); end
`endif
  endtask

`ifdef MULT_DONE_EN
  task automatic test_done_pulse;
    int cyc, dn;
    bit st;
    launch(12'hFFF, 8'h55, cyc, dn, st);
    n_cmp++;
    if (bus.done !== 1'b1) begin n_bad++; $display("FAIL done_at_fall: got %b want 1", bus.done); end
    n_cmp++;
    if (dn !== 1) begin n_bad++; $display("FAIL done_count: got %0d want 1", dn); end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0) begin n_bad++; $display("FAIL done_width: got %b want 0", bus.done); end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.start = 1'b0;
    bus.mpd = '0;
    bus.mpr = '0;
    test_reset();
    test_pos_pos();
    test_neg_pos();
    test_extremes();
    test_zero_alt();
    test_start_held();
    test_back_to_back();
    test_reset_mid();
`ifdef MULT_DONE_EN
    test_done_pulse();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/booth_mult.md
# booth_mult

Sequential radix-2 Booth multiplier for signed two's-complement operands: one Booth step per clock. Default configuration is a 12-bit multiplicand by an 8-bit multiplier giving a 20-bit product. It sits on a datapath as a start/busy coprocessor. Fixed-point scaling of operands and product belongs to the caller; this block performs pure integer multiplication. The RTL module name is `booth_mult`.

## Interface
- MBITS, 12, multiplicand width (signed)
- NBITS, 8, multiplier width (signed); also the iteration count
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled on the rising edge while idle
- mpd  input  MBITS  multiplicand, two's complement; sampled with start
- mpr  input  NBITS  multiplier, two's complement; sampled with start
- prod  output  MBITS+NBITS  signed product, registered
- busy  output  1  high while a multiplication is in progress
- done  output  1  one-cycle completion pulse; present only with MULT_DONE_EN

## Operation
- Internal state:
  - M: MBITS, latched mpd
  - A: MBITS+1-bit accumulator; the extra bit absorbs the −(−2^(MBITS−1)) case
  - Q: NBITS, latched mpr
  - q_1: 1-bit Booth extension
  - cnt: ceil(log2(NBITS+1)) bits
- States: IDLE and RUN.
- IDLE, start=1: load M=mpd, A=0, Q=mpr, q_1=0, cnt=0. Go to RUN and set busy=1.
- IDLE, start=0: hold all state.
- RUN: each edge performs one step:
  - {Q[0],q_1} = 01: A = A + sext(M)
  - {Q[0],q_1} = 10: A = A − sext(M)
  - {Q[0],q_1} = 00 or 11: no change to A
  - Then arithmetic right shift of {A,Q,q_1} by one (A MSB replicated).
  - Increment cnt.
- On the step where cnt reaches NBITS−1:
  - prod = {A[MBITS−1:0], Q} after that step's shift
  - busy=0; go to IDLE
- prod holds the last result until the next completion. It is not cleared or altered during RUN.
- start asserted while busy=1 is ignored. No queueing; operands are not re-sampled.
- mpd/mpr changes during RUN have no effect.
- Full signed range is exact. (−2^(MBITS−1))·(−2^(NBITS−1)) = +2^(MBITS+NBITS−2) fits without overflow.

## Timing
- Reset (rst_n=0, asynchronous): prod=0, busy=0, done=0, state IDLE, internal registers 0. Reset mid-operation aborts the operation. prod returns to 0, not to the previous result.
- Edge E0 samples start=1 while idle; busy goes high after E0.
- Edges E1..E_NBITS perform the Booth steps.
- At E_NBITS, prod is updated and busy falls. Latency is NBITS cycles from E0 (8 by default).
- A new start may be sampled at the edge after busy falls (E_NBITS+1) at the earliest. Back-to-back throughput is one result per NBITS+1 cycles.
- start held high across several edges launches only one operation while busy. If start is still high at E_NBITS+1, a new operation starts.

## Configuration
- MULT_DONE_EN defined:
  - `done` port exists.
  - `done` is registered and high for exactly the one cycle following E_NBITS (same edge busy falls).
  - Reset value of `done` is 0.
- MULT_DONE_EN undefined:
  - No `done` port or logic.
  - Completion is detected by busy falling.

## Test plan
- Positive×positive: mpd=12'h100 (256), mpr=8'h40 (64), 1-cycle start pulse:
  - busy high for exactly 8 cycles
  - then prod=20'h04000 (16384)
- Negative×positive: mpd=12'hB00 (−1280), mpr=8'h40, started 120 ns after the first operation:
  - prod=20'hEC000 (−81920)
  - prior result 20'h04000 held until completion
- Extremes:
  - mpd=12'h800, mpr=8'h80 → prod=20'h40000 (+262144)
  - mpd=12'h7FF, mpr=8'h80 → prod=20'hC0080 (−262016)
- Zero and alternating bits:
  - mpd=12'h123, mpr=8'h00 → prod=0
  - mpd=12'hFFF (−1), mpr=8'h55 (85) → prod=20'hFFFAB (−85)
- start held high 3 cycles and re-pulsed mid-RUN:
  - single operation, latency unchanged, result unaffected
- rst_n pulsed low at cycle 4 of RUN:
  - busy=0 and prod=0 immediately (asynchronous)
  - next start computes correctly
  - with MULT_DONE_EN: no done pulse for the aborted operation; one pulse per completed operation
